// File: rtl/mem_sequencer.sv
// mem_sequencer: arbitrates CPU and sprite-fetch access to the
// single CHIP-8 memory port; splits writes and wrapping reads.
module mem_sequencer #(
  parameter int MAX_LEN = 15,
  parameter int ADDR_W  = 12
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cpu_req,
  input  logic                   cpu_we,
  input  logic [ADDR_W-1:0]      cpu_addr,
  input  logic [3:0]             cpu_len,
  input  logic [8*MAX_LEN-1:0]   cpu_wdata,
  output logic                   cpu_ack,
  output logic [8*MAX_LEN-1:0]   cpu_rdata,
  input  logic                   gfx_req,
  input  logic [ADDR_W-1:0]      gfx_addr,
  input  logic [3:0]             gfx_len,
  output logic                   gfx_ack,
  output logic [8*MAX_LEN-1:0]   gfx_rdata,
  output logic                   mem_we,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [7:0]             mem_wdata,
  output logic [3:0]             mem_len,
  input  logic [8*MAX_LEN-1:0]   mem_rdata,
  output logic                   busy
);

  localparam int DW = 8 * MAX_LEN;

  typedef enum logic [2:0] {
    IDLE, RD_ISSUE, RD_CAPT, WR,
    RDB, RDB_DRAIN, DONE
  } state_t;

  state_t            state;
  logic              last_gfx;
  logic              sel_gfx;
  logic              first;
  logic [3:0]        rlen;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] nxt_addr;
  logic [DW-1:0]     wbuf;
  logic [DW-1:0]     rbuf;

  logic              pick_cpu;
  logic              pick_gfx;
  logic [ADDR_W-1:0] g_addr;
  logic [3:0]        g_len;
  logic              g_we;
  logic [ADDR_W:0]   g_end;
  logic              g_split;
  logic [DW-1:0]     wal;
  logic [DW-1:0]     split_res;

  function automatic logic [DW-1:0] lo_mask(
    input logic [3:0] n
  );
    lo_mask = ~({DW{1'b1}} << {n, 3'b000});
  endfunction

  // grant choice and request decode for the IDLE cycle
  always_comb begin
    pick_cpu = cpu_req && (!gfx_req || last_gfx);
    pick_gfx = gfx_req && !pick_cpu;
    g_addr   = pick_cpu ? cpu_addr : gfx_addr;
    g_len    = pick_cpu ? cpu_len : gfx_len;
    g_we     = pick_cpu && cpu_we;
    g_end    = {1'b0, g_addr}
             + {{(ADDR_W-3){1'b0}}, g_len};
    g_split  = g_end > {1'b1, {ADDR_W{1'b0}}};
    wal      = cpu_wdata
             << {4'(MAX_LEN) - cpu_len, 3'b000};
    split_res = {rbuf[DW-9:0], mem_rdata[7:0]};
  end

  // sequencer FSM with registered port and memory outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      last_gfx  <= 1'b1;
      sel_gfx   <= 1'b0;
      first     <= 1'b0;
      rlen      <= '0;
      cnt       <= '0;
      nxt_addr  <= '0;
      wbuf      <= '0;
      rbuf      <= '0;
      cpu_ack   <= 1'b0;
      gfx_ack   <= 1'b0;
      cpu_rdata <= '0;
      gfx_rdata <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_len   <= '0;
      busy      <= 1'b0;
    end else begin
      cpu_ack <= 1'b0;
      gfx_ack <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pick_cpu || pick_gfx) begin
            sel_gfx  <= pick_gfx;
            last_gfx <= pick_gfx;
            busy     <= 1'b1;
            rlen     <= g_len;
            cnt      <= 4'd1;
            first    <= 1'b1;
            rbuf     <= '0;
            nxt_addr <= g_addr + ADDR_W'(1);
            if (g_len == 4'd0) begin
              state <= DONE;
              if (pick_gfx) begin
                gfx_ack   <= 1'b1;
                gfx_rdata <= '0;
              end else begin
                cpu_ack   <= 1'b1;
                cpu_rdata <= '0;
              end
            end else if (g_we) begin
              state     <= WR;
              mem_we    <= 1'b1;
              mem_addr  <= g_addr;
              mem_wdata <= wal[DW-1 -: 8];
              wbuf      <= wal << 8;
            end else if (g_split) begin
              state    <= RDB;
              mem_addr <= g_addr;
              mem_len  <= 4'd1;
            end else begin
              state    <= RD_ISSUE;
              mem_addr <= g_addr;
              mem_len  <= g_len;
            end
          end
        end
        RD_ISSUE: begin
          mem_len <= '0;
          state   <= RD_CAPT;
        end
        RD_CAPT: begin
          state <= DONE;
          if (sel_gfx) begin
            gfx_ack   <= 1'b1;
            gfx_rdata <= mem_rdata & lo_mask(rlen);
          end else begin
            cpu_ack   <= 1'b1;
            cpu_rdata <= mem_rdata & lo_mask(rlen);
          end
        end
        WR: begin
          if (cnt == rlen) begin
            mem_we  <= 1'b0;
            state   <= DONE;
            cpu_ack <= 1'b1;
          end else begin
            mem_addr  <= nxt_addr;
            nxt_addr  <= nxt_addr + ADDR_W'(1);
            mem_wdata <= wbuf[DW-1 -: 8];
            wbuf      <= wbuf << 8;
            cnt       <= cnt + 4'd1;
          end
        end
        RDB: begin
          if (!first) rbuf <= split_res;
          first <= 1'b0;
          if (cnt == rlen) begin
            mem_len <= '0;
            state   <= RDB_DRAIN;
          end else begin
            mem_addr <= nxt_addr;
            nxt_addr <= nxt_addr + ADDR_W'(1);
            cnt      <= cnt + 4'd1;
          end
        end
        RDB_DRAIN: begin
          state <= DONE;
          if (sel_gfx) begin
            gfx_ack   <= 1'b1;
            gfx_rdata <= split_res;
          end else begin
            cpu_ack   <= 1'b1;
            cpu_rdata <= split_res;
          end
        end
        DONE: begin
          mem_we <= 1'b0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_sequencer.sv
// tb_mem_sequencer: directed bench with a memory device, a
// transaction-level timeline model and a per-cycle compare.
module tb_mem_sequencer;

  localparam int N = 4096;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cpu_req = 1'b0;
  logic         cpu_we = 1'b0;
  logic [11:0]  cpu_addr = '0;
  logic [3:0]   cpu_len = '0;
  logic [119:0] cpu_wdata = '0;
  logic         cpu_ack;
  logic [119:0] cpu_rdata;
  logic         gfx_req = 1'b0;
  logic [11:0]  gfx_addr = '0;
  logic [3:0]   gfx_len = '0;
  logic         gfx_ack;
  logic [119:0] gfx_rdata;
  logic         mem_we;
  logic [11:0]  mem_addr;
  logic [7:0]   mem_wdata;
  logic [3:0]   mem_len;
  logic [119:0] mem_rdata = '0;
  logic         busy;

  mem_sequencer dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_len(cpu_len),
    .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack),
    .cpu_rdata(cpu_rdata),
    .gfx_req(gfx_req), .gfx_addr(gfx_addr),
    .gfx_len(gfx_len), .gfx_ack(gfx_ack),
    .gfx_rdata(gfx_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_len(mem_len),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  bit started = 0;
  int c_lat, g_lat;

  logic [7:0] mem [N];
  logic [7:0] shadow [N];

  logic         e_we   [N];
  logic [11:0]  e_addr [N];
  logic [7:0]   e_wd   [N];
  logic         e_rd   [N];
  logic [3:0]   e_len  [N];
  logic         e_busy [N];
  logic         e_cack [N];
  logic         e_gack [N];
  logic         e_cupd [N];
  logic         e_gupd [N];
  logic [119:0] e_cval [N];
  logic [119:0] e_gval [N];

  logic [119:0] m_crd = '0;
  logic [119:0] m_grd = '0;
  bit   m_last_gfx = 1;
  int   idle_from = 0;

  task automatic chk(input string nm,
                     input logic [119:0] act,
                     input logic [119:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%h exp=%h",
                  nm, cyc, act, exp);
  endtask

  function automatic void clr(input int c);
    e_we[c] = 0; e_addr[c] = '0; e_wd[c] = '0;
    e_rd[c] = 0; e_len[c] = '0; e_busy[c] = 0;
    e_cack[c] = 0; e_gack[c] = 0;
    e_cupd[c] = 0; e_gupd[c] = 0;
    e_cval[c] = '0; e_gval[c] = '0;
  endfunction

  initial begin
    for (int i = 0; i < N; i++) begin
      mem[i] = 8'(i) ^ 8'h5A;
      shadow[i] = 8'(i) ^ 8'h5A;
      clr(i);
    end
  end

  function automatic logic [119:0] pack(
    input logic [11:0] a, input logic [3:0] l);
    logic [119:0] v;
    v = '0;
    for (int k = 0; k < int'(l); k++)
      v = {v[111:0], mem[a + 12'(k)]};
    return v;
  endfunction

  // memory device: byte write, registered burst read
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= pack(mem_addr, mem_len);
  end

  // transaction-level model: on each grant, lay out the
  // whole expected timeline into per-cycle tables
  always @(posedge clk) begin : model
    int n, a, l, done;
    bit g, w;
    logic [119:0] d, v;
    n = cyc;
    if (e_we[n]) shadow[e_addr[n]] = e_wd[n];
    if (rst) begin
      for (int i = n + 1; i < n + 40; i++) clr(i);
      e_cupd[n+1] = 1; e_gupd[n+1] = 1;
      idle_from = n + 1;
      m_last_gfx = 1;
      started = 1;
    end else if (started && n >= idle_from &&
                 (cpu_req || gfx_req)) begin
      if (cpu_req && gfx_req) g = !m_last_gfx;
      else g = gfx_req;
      m_last_gfx = g;
      a = g ? int'(gfx_addr) : int'(cpu_addr);
      l = g ? int'(gfx_len) : int'(cpu_len);
      w = !g && cpu_we;
      d = cpu_wdata;
      v = '0;
      if (l == 0) begin
        done = n + 1;
      end else if (w) begin
        for (int k = 0; k < l; k++) begin
          e_we[n+1+k] = 1;
          e_addr[n+1+k] = 12'((a + k) % 4096);
          v = d >> (8 * (l - 1 - k));
          e_wd[n+1+k] = v[7:0];
        end
        done = n + l + 1;
      end else begin
        for (int k = 0; k < l; k++)
          v = {v[111:0], shadow[12'((a + k) % 4096)]};
        if (a + l <= 4096) begin
          e_rd[n+1] = 1;
          e_addr[n+1] = 12'(a);
          e_len[n+1] = 4'(l);
          done = n + 3;
        end else begin
          for (int k = 0; k < l; k++) begin
            e_rd[n+1+k] = 1;
            e_addr[n+1+k] = 12'((a + k) % 4096);
            e_len[n+1+k] = 4'd1;
          end
          done = n + l + 2;
        end
      end
      for (int c = n + 1; c <= done; c++) e_busy[c] = 1;
      if (g) begin
        e_gack[done] = 1;
        e_gupd[done] = 1; e_gval[done] = v;
      end else begin
        e_cack[done] = 1;
        if (!w) begin
          e_cupd[done] = 1; e_cval[done] = v;
        end
      end
      idle_from = done + 1;
    end
    cyc = cyc + 1;
  end

  // per-cycle compare of every registered output
  always @(negedge clk) begin : compare
    int c;
    c = cyc;
    if (started && c > 0) begin
      if (e_cupd[c]) m_crd = e_cval[c];
      if (e_gupd[c]) m_grd = e_gval[c];
      chk("mem_we", 120'(mem_we), 120'(e_we[c]));
      chk("busy", 120'(busy), 120'(e_busy[c]));
      chk("cpu_ack", 120'(cpu_ack), 120'(e_cack[c]));
      chk("gfx_ack", 120'(gfx_ack), 120'(e_gack[c]));
      chk("cpu_rdata", cpu_rdata, m_crd);
      chk("gfx_rdata", gfx_rdata, m_grd);
      if (e_we[c]) begin
        chk("wr_addr", 120'(mem_addr), 120'(e_addr[c]));
        chk("wr_data", 120'(mem_wdata), 120'(e_wd[c]));
      end
      if (e_rd[c]) begin
        chk("rd_addr", 120'(mem_addr), 120'(e_addr[c]));
        chk("rd_len", 120'(mem_len), 120'(e_len[c]));
      end
      if (!e_busy[c])
        chk("idle_len", 120'(mem_len), 120'(0));
    end
  end

  task automatic go(
    input bit con, input bit cwe,
    input logic [11:0] ca, input logic [3:0] cl,
    input logic [119:0] cw,
    input bit gon, input logic [11:0] ga,
    input logic [3:0] gl);
    int t0;
    bit fin;
    @(negedge clk);
    t0 = cyc;
    c_lat = -1;
    g_lat = -1;
    if (con) begin
      cpu_req = 1; cpu_we = cwe; cpu_addr = ca;
      cpu_len = cl; cpu_wdata = cw;
    end
    if (gon) begin
      gfx_req = 1; gfx_addr = ga; gfx_len = gl;
    end
    fin = 0;
    for (int i = 0; i < 64 && !fin; i++) begin
      @(negedge clk);
      if (cpu_req && cpu_ack) begin
        cpu_req = 0; c_lat = cyc - t0;
      end
      if (gfx_req && gfx_ack) begin
        gfx_req = 0; g_lat = cyc - t0;
      end
      fin = !cpu_req && !gfx_req;
    end
    if (!fin) begin
      n_chk++;
      $display("FAIL timeout cyc=%0d got=no_ack exp=ack",
               cyc);
      cpu_req = 0;
      gfx_req = 0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
  endtask

  initial begin : watchdog
    #50000;
    $display("FAIL watchdog cyc=%0d got=hang exp=finish", cyc);
    $fatal(1);
  end

  initial begin : stim
    int t0, acks;
    repeat (3) @(negedge clk);
    chk("rst_busy", 120'(busy), 120'(0));
    chk("rst_we", 120'(mem_we), 120'(0));
    chk("rst_addr", 120'(mem_addr), 120'(0));
    chk("rst_wdata", 120'(mem_wdata), 120'(0));
    chk("rst_len", 120'(mem_len), 120'(0));
    chk("rst_crd", cpu_rdata, 120'(0));
    chk("rst_grd", gfx_rdata, 120'(0));
    chk("rst_acks", 120'({cpu_ack, gfx_ack}), 120'(0));
    rst = 0;

    go(1, 1, 12'h300, 4'd3, 120'hAABBCC, 0, '0, '0);
    chk("wr3_lat", 120'(c_lat), 120'(4));
    go(0, 0, '0, '0, '0, 1, 12'h300, 4'd3);
    chk("rb3_lat", 120'(g_lat), 120'(3));
    chk("rb3_data", gfx_rdata, 120'hAABBCC);

    go(1, 0, 12'h010, 4'd2, '0, 0, '0, '0);
    chk("crd2_data", cpu_rdata, 120'h4A4B);
    go(0, 0, '0, '0, '0, 1, 12'h200, 4'd5);
    chk("pong_lat", 120'(g_lat), 120'(3));
    chk("pong_data", gfx_rdata, 120'h5A5B58595E);
    chk("pong_crd", cpu_rdata, 120'h4A4B);

    go(1, 0, 12'hFF1, 4'd15, '0, 0, '0, '0);
    chk("edge_lat", 120'(c_lat), 120'(3));

    do_reset();
    go(1, 0, 12'h020, 4'd1, '0, 1, 12'h021, 4'd1);
    chk("tie1_c", 120'(c_lat), 120'(3));
    chk("tie1_g", 120'(g_lat), 120'(7));
    go(1, 0, 12'h030, 4'd1, '0, 0, '0, '0);
    go(1, 0, 12'h020, 4'd1, '0, 1, 12'h021, 4'd1);
    chk("tie2_g", 120'(g_lat), 120'(3));
    chk("tie2_c", 120'(c_lat), 120'(7));

    go(1, 1, 12'hFFF, 4'd2, 120'hD1D2, 0, '0, '0);
    chk("wrap_wlat", 120'(c_lat), 120'(3));
    go(0, 0, '0, '0, '0, 1, 12'hFFE, 4'd4);
    chk("split_lat", 120'(g_lat), 120'(6));
    chk("split_data", gfx_rdata, 120'hA4D1D25B);

    go(0, 0, '0, '0, '0, 1, 12'h100, 4'd0);
    chk("len0_lat", 120'(g_lat), 120'(1));
    chk("len0_data", gfx_rdata, 120'(0));

    @(negedge clk);
    t0 = cyc;
    cpu_req = 1; cpu_we = 1; cpu_addr = 12'h400;
    cpu_len = 4'd8; cpu_wdata = 120'h1122334455667788;
    @(negedge clk);
    @(negedge clk);
    chk("rmid_we", 120'(mem_we), 120'(1));
    rst = 1;
    cpu_req = 0;
    @(negedge clk);
    rst = 0;
    chk("rmid_cyc", 120'(cyc - t0), 120'(3));
    chk("rmid_idle", 120'({mem_we, busy}), 120'(0));
    acks = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (cpu_ack) acks++;
    end
    chk("rmid_noack", 120'(acks), 120'(0));
    go(0, 0, '0, '0, '0, 1, 12'h400, 4'd8);
    chk("rmid_data", gfx_rdata, 120'h112258595E5F5C5D);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
